// File: rtl/i2c_master_rw.sv
// I2C master: START, 7-bit address + R/W, 0..2^LEN_W-1 data bytes, STOP.
// Open-drain SCL/SDA enables; each bit slot is four quarters of QTR clocks.
module i2c_master_rw #(
   parameter int unsigned CLK_FREQ = 100_000_000,
   parameter int unsigned SCL_FREQ = 100_000,
   parameter int unsigned LEN_W    = 4,
   parameter int unsigned QTR      = CLK_FREQ / (SCL_FREQ * 4)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [6:0]       addr,
   input  logic             rw,
   input  logic [LEN_W-1:0] num_bytes,
   input  logic [7:0]       wr_data,
   output logic             wr_load,
   output logic [7:0]       rd_data,
   output logic             rd_valid,
   output logic             scl_oe,
   output logic             sda_oe,
   input  logic             sda_i,
   output logic             busy,
   output logic             done,
   output logic             ack_err
);

   localparam int unsigned QW = $clog2(QTR);
   localparam logic [QW-1:0] Q_LAST = QW'(QTR - 1);
   localparam logic [QW-1:0] Q_PENULT = QW'(QTR - 2);

   typedef enum logic [3:0] {
      S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WRITE,
      S_WRITE_ACK, S_READ, S_READ_ACK, S_STOP
   } state_t;

   state_t           state_q, state_d;
   logic [QW-1:0]    qcnt_q, qcnt_d;
   logic [1:0]       qtr_q, qtr_d;
   logic [2:0]       bit_q, bit_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [7:0]       shift_q, shift_d;
   logic             rw_q, rw_d;
   logic             samp_q, samp_d;
   logic             scl_oe_q, scl_oe_d;
   logic             sda_oe_q, sda_oe_d;
   logic             wr_load_q, wr_load_d;
   logic [7:0]       rd_data_q, rd_data_d;
   logic             rd_valid_q, rd_valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             ack_err_q, ack_err_d;

   logic tick, samp_pt, slot_end;

   assign tick     = (state_q != S_IDLE) && (qcnt_q == Q_LAST);
   assign samp_pt  = tick && (qtr_q == 2'd2);
   assign slot_end = tick && (qtr_q == 2'd3);

   always_comb begin
      state_d    = state_q;
      qcnt_d     = qcnt_q;
      qtr_d      = qtr_q;
      bit_d      = bit_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      rw_d       = rw_q;
      samp_d     = samp_q;
      wr_load_d  = 1'b0;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      busy_d     = busy_q;
      done_d     = 1'b0;
      ack_err_d  = ack_err_q;

      if (state_q != S_IDLE) begin
         if (tick) begin
            qcnt_d = '0;
            qtr_d  = qtr_q + 2'd1;
         end else begin
            qcnt_d = qcnt_q + QW'(1);
         end
      end
      if (samp_pt)
         samp_d = sda_i;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               shift_d   = {addr, rw};
               rw_d      = rw;
               cnt_d     = num_bytes;
               ack_err_d = 1'b0;
               busy_d    = 1'b1;
               qcnt_d    = '0;
               qtr_d     = '0;
               bit_d     = '0;
               state_d   = S_START;
            end
         end
         S_START: begin
            if (slot_end)
               state_d = S_ADDR;
         end
         S_ADDR: begin
            if (slot_end) begin
               shift_d = {shift_q[6:0], 1'b0};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7)
                  state_d = S_ADDR_ACK;
            end
         end
         S_ADDR_ACK: begin
            if (slot_end) begin
               if (samp_q) begin
                  ack_err_d = 1'b1;
                  state_d   = S_STOP;
               end else if (cnt_q == '0) begin
                  state_d = S_STOP;
               end else if (!rw_q) begin
                  wr_load_d = 1'b1;
                  state_d   = S_WRITE;
               end else begin
                  state_d = S_READ;
               end
            end
         end
         S_WRITE: begin
            // wr_load is high during the first clk of the byte; capture then
            if (wr_load_q)
               shift_d = wr_data;
            if (slot_end) begin
               shift_d = {shift_q[6:0], 1'b0};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7)
                  state_d = S_WRITE_ACK;
            end
         end
         S_WRITE_ACK: begin
            if (slot_end) begin
               if (samp_q) begin
                  ack_err_d = 1'b1;
                  state_d   = S_STOP;
               end else begin
                  cnt_d = cnt_q - LEN_W'(1);
                  if (cnt_q == LEN_W'(1)) begin
                     state_d = S_STOP;
                  end else begin
                     wr_load_d = 1'b1;
                     state_d   = S_WRITE;
                  end
               end
            end
         end
         S_READ: begin
            if (samp_pt)
               shift_d = {shift_q[6:0], sda_i};
            if (slot_end) begin
               bit_d = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  rd_data_d  = shift_q;
                  rd_valid_d = 1'b1;
                  state_d    = S_READ_ACK;
               end
            end
         end
         S_READ_ACK: begin
            if (slot_end) begin
               cnt_d   = cnt_q - LEN_W'(1);
               state_d = (cnt_q == LEN_W'(1)) ? S_STOP : S_READ;
            end
         end
         S_STOP: begin
            // done/busy are registered, so raise them one clk early to land on the last clk
            if ((qtr_q == 2'd3) && (qcnt_q == Q_PENULT)) begin
               done_d = 1'b1;
               busy_d = 1'b0;
            end
            if (slot_end)
               state_d = S_IDLE;
         end
      endcase

      // Line enables follow the next state so they change with the quarter boundary
      scl_oe_d = 1'b0;
      sda_oe_d = 1'b0;
      case (state_d)
         S_START: sda_oe_d = qtr_d[1];
         S_ADDR, S_WRITE: begin
            scl_oe_d = ~qtr_d[1];
            sda_oe_d = ~shift_d[7];
         end
         S_ADDR_ACK, S_WRITE_ACK, S_READ: scl_oe_d = ~qtr_d[1];
         S_READ_ACK: begin
            scl_oe_d = ~qtr_d[1];
            sda_oe_d = (cnt_d > LEN_W'(1));
         end
         S_STOP: begin
            scl_oe_d = ~qtr_d[1];
            sda_oe_d = (qtr_d != 2'd3);
         end
         default: begin
            scl_oe_d = 1'b0;
            sda_oe_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         qcnt_q     <= '0;
         qtr_q      <= '0;
         bit_q      <= '0;
         cnt_q      <= '0;
         shift_q    <= '0;
         rw_q       <= 1'b0;
         samp_q     <= 1'b0;
         scl_oe_q   <= 1'b0;
         sda_oe_q   <= 1'b0;
         wr_load_q  <= 1'b0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         ack_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         qcnt_q     <= qcnt_d;
         qtr_q      <= qtr_d;
         bit_q      <= bit_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         rw_q       <= rw_d;
         samp_q     <= samp_d;
         scl_oe_q   <= scl_oe_d;
         sda_oe_q   <= sda_oe_d;
         wr_load_q  <= wr_load_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         ack_err_q  <= ack_err_d;
      end
   end

   assign wr_load  = wr_load_q;
   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign scl_oe   = scl_oe_q;
   assign sda_oe   = sda_oe_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign ack_err  = ack_err_q;

endmodule

// File: tb/tb_i2c_master_rw.sv
// Scoreboard bench for i2c_master_rw: expected bus bits and output events are
// queued by the stimulus and popped by monitors as the DUT produces them.
module tb_i2c_master_rw;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [6:0] addr;
   logic       rw;
   logic [3:0] num_bytes;
   logic [7:0] wr_data;
   logic       wr_load;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       scl_oe;
   logic       sda_oe;
   logic       sda_i;
   logic       busy;
   logic       done;
   logic       ack_err;

   i2c_master_rw #(.CLK_FREQ(4_000_000), .SCL_FREQ(100_000)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .addr(addr), .rw(rw),
      .num_bytes(num_bytes), .wr_data(wr_data), .wr_load(wr_load),
      .rd_data(rd_data), .rd_valid(rd_valid), .scl_oe(scl_oe),
      .sda_oe(sda_oe), .sda_i(sda_i), .busy(busy), .done(done),
      .ack_err(ack_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int kind;   // 0 wr_load, 1 rd_valid, 2 done
      int val;
      int cyc;
   } ev_t;

   ev_t        evq[$];
   logic       eb[$];     // expected sda_oe at each SCL rise
   logic       sl[$];     // slave pull-low per slot
   logic [7:0] wq[$];
   int         n_vec = 0;
   int         n_bad = 0;
   int         cyc = 0;
   int         t0 = 0;
   int         slot = -1;
   logic       pull = 1'b0;
   logic       scl_prev = 1'b0;

   assign sda_i = ~(sda_oe | pull);

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_ev(input int k, input int v, input int c);
      ev_t e;
      if (evq.size() == 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL unexpected_event: got kind %0d expected none (t=%0t)", k, $time);
      end else begin
         e = evq.pop_front();
         chk("event_kind", k, e.kind);
         if (k == e.kind) begin
            chk("event_value", v, e.val);
            if (k == 2) chk("done_cycle", c, e.cyc);
         end
      end
   endtask

   // Slave model plus bit monitor on SCL edges
   always @(negedge clk) begin
      if (scl_oe && !scl_prev) begin
         slot = slot + 1;
         pull = (slot < sl.size()) ? sl[slot] : 1'b0;
      end
      if (!scl_oe && scl_prev && eb.size() > 0)
         chk($sformatf("sda_bit_slot%0d", slot), sda_oe, eb.pop_front());
      scl_prev = scl_oe;
   end

   always @(negedge clk) begin
      if (wr_load)  check_ev(0, 0, 0);
      if (rd_valid) check_ev(1, rd_data, 0);
      if (done)     check_ev(2, ack_err, cyc - t0);
   end

   always @(negedge clk) begin
      if (wr_load) begin
         @(posedge clk);
         #1;
         if (wq.size() > 0) void'(wq.pop_front());
         wr_data = (wq.size() > 0) ? wq[0] : 8'h00;
      end
   end

   task automatic exp_byte(input logic [7:0] b, input logic ack_pull);
      for (int i = 7; i >= 0; i--) begin
         eb.push_back(~b[i]);
         sl.push_back(1'b0);
      end
      eb.push_back(1'b0);
      sl.push_back(ack_pull);
   endtask

   task automatic exp_rd(input logic [7:0] b, input logic mack);
      for (int i = 7; i >= 0; i--) begin
         eb.push_back(1'b0);
         sl.push_back(~b[i]);
      end
      eb.push_back(mack);
      sl.push_back(1'b0);
      evq.push_back('{1, int'(b), 0});
   endtask

   task automatic set_wq(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
      wq.delete();
      wq.push_back(b0);
      wq.push_back(b1);
      wq.push_back(b2);
      wr_data = b0;
   endtask

   task automatic issue_start(input logic [6:0] a, input logic r, input logic [3:0] n);
      slot = -1;
      pull = 1'b0;
      @(negedge clk);
      addr = a; rw = r; num_bytes = n; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      t0 = cyc;
      chk("busy_after_start", busy, 1);
      chk("ack_err_cleared", ack_err, 0);
   endtask

   task automatic wait_done(input logic poke_on_done);
      int i;
      for (i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (done) break;
      end
      if (i == 3000) begin
         n_vec++;
         n_bad++;
         $display("FAIL done_timeout: got no done expected done within 3000 clk");
      end else if (poke_on_done) begin
         addr = 7'h12; rw = 1'b0; num_bytes = 4'd1; start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         chk("start_on_done_ignored", busy, 0);
      end
      repeat (5) @(negedge clk);
      sl.delete();
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; addr = '0; rw = 1'b0; num_bytes = '0; wr_data = '0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", {scl_oe, sda_oe, busy, done, ack_err, wr_load, rd_valid, rd_data}, 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // write 2 bytes to 0x50
      set_wq(8'hA5, 8'h3C, 8'h00);
      exp_byte(8'hA0, 1'b1); exp_byte(8'hA5, 1'b1); exp_byte(8'h3C, 1'b1);
      evq.push_back('{0, 0, 0}); evq.push_back('{0, 0, 0}); evq.push_back('{2, 0, 1159});
      issue_start(7'h50, 1'b0, 4'd2);
      wait_done(1'b0);

      // read 3 bytes from 0x68
      exp_byte(8'hD1, 1'b1);
      exp_rd(8'h11, 1'b1); exp_rd(8'h22, 1'b1); exp_rd(8'h33, 1'b0);
      evq.push_back('{2, 0, 1519});
      issue_start(7'h68, 1'b1, 4'd3);
      wait_done(1'b0);

      // address NACK
      set_wq(8'h11, 8'h22, 8'h00);
      exp_byte(8'hFE, 1'b0);
      evq.push_back('{2, 1, 439});
      issue_start(7'h7F, 1'b0, 4'd2);
      wait_done(1'b0);

      // NACK on first write byte of three
      set_wq(8'hC3, 8'h5A, 8'h0F);
      exp_byte(8'h74, 1'b1); exp_byte(8'hC3, 1'b0);
      evq.push_back('{0, 0, 0}); evq.push_back('{2, 1, 799});
      issue_start(7'h3A, 1'b0, 4'd3);
      wait_done(1'b0);

      // address-only probe; start pulsed in the done cycle
      exp_byte(8'h42, 1'b1);
      evq.push_back('{2, 0, 439});
      issue_start(7'h21, 1'b0, 4'd0);
      wait_done(1'b1);

      // asynchronous reset during the 5th address bit
      set_wq(8'h99, 8'h00, 8'h00);
      sl.push_back(1'b0);
      issue_start(7'h55, 1'b0, 4'd1);
      for (int i = 0; i < 2000 && slot < 4; i++) @(negedge clk);
      chk("reached_bit5", (slot >= 4), 1);
      repeat (15) @(negedge clk);
      chk("pre_reset_scl_low", scl_oe, 1);
      eb.delete();
      #2 rst_n = 1'b0;
      #1 chk("async_reset_lines", {scl_oe, sda_oe, busy, done, ack_err, wr_load, rd_valid, rd_data}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("no_stop_after_reset", {scl_oe, sda_oe, busy}, 0);

      // full transfer after reset; start while busy ignored
      sl.delete();
      set_wq(8'h81, 8'h00, 8'h00);
      exp_byte(8'h54, 1'b1); exp_byte(8'h81, 1'b1);
      evq.push_back('{0, 0, 0}); evq.push_back('{2, 0, 799});
      issue_start(7'h2A, 1'b0, 4'd1);
      repeat (100) @(negedge clk);
      addr = 7'h7F; rw = 1'b1; num_bytes = 4'd5; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(1'b0);

      chk("events_left", evq.size(), 0);
      chk("bits_left", eb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
